// File: rtl/icon_bitmap_loader.sv
// Icon bitmap write path: packs CPU bus words into icon rows and stores them in an
// orientation-banked row RAM, with a registered read port for the renderer.
module icon_bitmap_loader #(
    parameter int unsigned ROWS   = 16,
    parameter int unsigned BPP    = 4,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned BANKS  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(BANKS)-1:0]   start_bank,
    input  logic                       abort,
    input  logic                       wr_valid,
    input  logic [WORD_W-1:0]          wr_data,
    output logic                       wr_ready,
    output logic                       busy,
    output logic                       done,
    input  logic [$clog2(BANKS)-1:0]   rd_bank,
    input  logic [$clog2(ROWS)-1:0]    rd_row,
    output logic [ROWS*BPP-1:0]        rd_data
);

    localparam int unsigned ROW_W = ROWS * BPP;
    localparam int unsigned WPR   = ROW_W / WORD_W;
    localparam int unsigned WW    = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int unsigned BW    = $clog2(BANKS);
    localparam int unsigned RW    = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        COMMIT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [BW-1:0]     bank;
    logic [RW-1:0]     row;
    logic [WW-1:0]     word;
    logic [ROW_W-1:0]  row_buf;
    logic              last_row;
    logic              mem_we;

    // Row storage; not reset, contents survive a loader reset.
    logic [ROW_W-1:0]  mem [BANKS*ROWS];

    assign last_row = (row == RW'(ROWS - 1));
    assign mem_we   = (state == COMMIT) && !abort;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = RECV;
                RECV:    if (wr_valid && word == WW'(WPR - 1)) next_state = COMMIT;
                COMMIT:  next_state = last_row ? IDLE : RECV;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ready = (state == RECV);
        busy     = (state != IDLE);
        done     = (state == COMMIT) && last_row && !abort;
    end

    // Abort suppresses every datapath update, so a discarded row leaves no trace.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank    <= '0;
            row     <= '0;
            word    <= '0;
            row_buf <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bank <= start_bank;
                        row  <= '0;
                        word <= '0;
                    end
                end
                RECV: begin
                    if (wr_valid) begin
                        for (int unsigned w = 0; w < WPR; w++) begin
                            if (word == WW'(w)) begin
                                row_buf[ROW_W-1-w*WORD_W -: WORD_W] <= wr_data;
                            end
                        end
                        if (word != WW'(WPR - 1)) begin
                            word <= word + WW'(1);
                        end
                    end
                end
                COMMIT: begin
                    word <= '0;
                    if (!last_row) begin
                        row <= row + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[{bank, row}] <= row_buf;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rd_bank, rd_row}];
        end
    end

endmodule

// File: tb/tb_icon_bitmap_loader.sv
// Directed bench for icon_bitmap_loader: bank loads, stalls, abort, ignored start,
// read-before-write collision and mid-load reset, finished by a table of readback vectors.
module tb_icon_bitmap_loader;

    localparam int ROWS = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  start_bank = '0;
    logic        abort = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic [1:0]  rd_bank = '0;
    logic [3:0]  rd_row = '0;
    logic [63:0] rd_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [63:0] model [4][16];

    typedef struct {
        logic [1:0]  bank;
        logic [3:0]  row;
        logic [63:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [12];

    icon_bitmap_loader #(.ROWS(16), .BPP(4), .WORD_W(32), .BANKS(4)) dut (
        .clock(clock), .reset(reset), .start(start), .start_bank(start_bank),
        .abort(abort), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done), .rd_bank(rd_bank), .rd_row(rd_row), .rd_data(rd_data)
    );

    initial forever #5 clock = ~clock;

    always @(negedge clock) if (done) done_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input bit rnd);
        int n;
        if (rnd) begin
            wr_valid = 1'b0;
            n = $urandom_range(0, 3);
            repeat (n) tick();
        end
        wr_valid = 1'b1;
        wr_data  = d;
        n = 0;
        while (!wr_ready && n < 8) begin
            tick();
            n++;
        end
        check("wr_ready_wait", wr_ready, 1);
        tick();
        if (rnd) wr_valid = 1'b0;
    endtask

    task automatic read_row(input logic [1:0] b, input logic [3:0] r, output logic [63:0] d);
        rd_bank = b;
        rd_row  = r;
        tick();
        d = rd_data;
    endtask

    // Leaves the loader in the COMMIT cycle of the last row when nrows < ROWS.
    task automatic load_bank(input logic [1:0] b, input logic [31:0] hi, input logic [31:0] lo,
                             input int nrows, input bit rnd, input bit intrude,
                             input int probe_row, output int elapsed);
        int s;
        int dc0;
        s = cyc;
        dc0 = done_cnt;
        elapsed = -1;
        start = 1'b1;
        start_bank = b;
        tick();
        start = 1'b0;
        start_bank = ~b;
        check("busy_after_start", busy, 1);
        for (int r = 0; r < nrows; r++) begin
            if (intrude && r == 8) begin
                start = 1'b1;
                start_bank = 2'd3;
            end
            send_word(hi, rnd);
            start = 1'b0;
            send_word(lo, rnd);
            check("done_row", done, (r == ROWS - 1));
            if (r == ROWS - 1) begin
                elapsed = cyc - s;
                check("done_not_early", done_cnt, dc0);
            end
            if (r == probe_row) begin
                wr_valid = 1'b0;
                rd_bank = b;
                rd_row = 4'(r);
                tick();
                check("collide_old", rd_data, model[b][r]);
                model[b][r] = {hi, lo};
                tick();
                check("collide_new", rd_data, model[b][r]);
            end else begin
                model[b][r] = {hi, lo};
            end
        end
        if (nrows == ROWS) begin
            wr_valid = 1'b0;
            tick();
            check("idle_after_done", busy, 0);
            check("done_count", done_cnt, dc0 + 1);
        end
    endtask

    initial begin
        int el;
        int dc;
        logic [63:0] d;

        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 16; r++) model[b][r] = '0;

        vecs[0]  = '{2'd2, 4'd0,  64'h0123456789ABCDEF};
        vecs[1]  = '{2'd2, 4'd15, 64'h0123456789ABCDEF};
        vecs[2]  = '{2'd0, 4'd4,  64'h0123456789ABCDEF};
        vecs[3]  = '{2'd0, 4'd15, 64'h0123456789ABCDEF};
        vecs[4]  = '{2'd1, 4'd0,  64'hB0B1B2B3B4B5B6B7};
        vecs[5]  = '{2'd1, 4'd6,  64'hB0B1B2B3B4B5B6B7};
        vecs[6]  = '{2'd1, 4'd7,  64'hA0A1A2A3A4A5A6A7};
        vecs[7]  = '{2'd1, 4'd15, 64'hA0A1A2A3A4A5A6A7};
        vecs[8]  = '{2'd3, 4'd4,  64'hE0E1E2E3E4E5E6E7};
        vecs[9]  = '{2'd3, 4'd5,  64'hC0C1C2C3C4C5C6C7};
        vecs[10] = '{2'd3, 4'd15, 64'hC0C1C2C3C4C5C6C7};
        vecs[11] = '{2'd3, 4'd0,  64'hE0E1E2E3E4E5E6E7};

        repeat (2) tick();
        check("rst_wr_ready", wr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 1'b0;
        tick();

        // Start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", busy, 0);

        load_bank(2'd3, 32'hC0C1C2C3, 32'hC4C5C6C7, ROWS, 1'b0, 1'b0, -1, el);
        load_bank(2'd1, 32'hA0A1A2A3, 32'hA4A5A6A7, ROWS, 1'b0, 1'b0, -1, el);
        load_bank(2'd0, 32'hD0D1D2D3, 32'hD4D5D6D7, ROWS, 1'b0, 1'b0, -1, el);

        // Full-rate load with an ignored start to bank 3 midway.
        load_bank(2'd2, 32'h01234567, 32'h89ABCDEF, ROWS, 1'b0, 1'b1, -1, el);
        check("done_latency", el, 48);

        // Stalled load, probing the row written in its own COMMIT cycle.
        load_bank(2'd0, 32'h01234567, 32'h89ABCDEF, ROWS, 1'b1, 1'b0, 4, el);

        // Abort during the COMMIT of row 7 of bank 1.
        dc = done_cnt;
        load_bank(2'd1, 32'hB0B1B2B3, 32'hB4B5B6B7, 7, 1'b0, 1'b0, -1, el);
        send_word(32'hB0B1B2B3, 1'b0);
        send_word(32'hB4B5B6B7, 1'b0);
        wr_valid = 1'b0;
        abort = 1'b1;
        #1;
        check("abort_done_suppressed", done, 0);
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        tick();
        check("abort_no_done", done_cnt, dc);

        // Asynchronous reset while waiting for word 1 of row 5 in bank 3.
        load_bank(2'd3, 32'hE0E1E2E3, 32'hE4E5E6E7, 5, 1'b0, 1'b0, -1, el);
        send_word(32'hE0E1E2E3, 1'b0);
        wr_valid = 1'b0;
        rd_bank = 2'd3;
        rd_row = 4'd0;
        tick();
        check("pre_reset_busy", busy, 1);
        #3;
        reset = 1'b1;
        #1;
        check("async_wr_ready", wr_ready, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_rd_data", rd_data, 0);
        tick();
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            read_row(vecs[i].bank, vecs[i].row, d);
            check($sformatf("vec%0d_b%0d_r%0d", i, vecs[i].bank, vecs[i].row), d, vecs[i].exp);
        end

        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 16; r++) begin
                read_row(2'(b), 4'(r), d);
                check($sformatf("sweep_b%0d_r%0d", b, r), d, model[b][r]);
            end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
